// File: rtl/sr_latch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_latch_pkg
// Brief    : Shared encodings and helpers for the SR latch bank write sequencer
// Revision : 1.0 - initial release
// ============================================================================
package sr_latch_pkg;

    // Sequencer state encodings (3 bits)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_ENABLE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_REJECT = 3'd5;

    // Command operation codes carried on cmd_val
    localparam logic OP_SET   = 1'b1;
    localparam logic OP_CLEAR = 1'b0;

    typedef enum logic [2:0] {
        STATE_IDLE   = ST_IDLE,
        STATE_SETUP  = ST_SETUP,
        STATE_ENABLE = ST_ENABLE,
        STATE_HOLD   = ST_HOLD,
        STATE_CHECK  = ST_CHECK,
        STATE_REJECT = ST_REJECT
    } state_t;

    // Largest of three phase durations; sizes the shared phase counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sr_latch_bank_seq_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : phase_timer
// Brief    : Loadable down-counter timing the SETUP/ENABLE/HOLD phases
// Revision : 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_tick,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load takes priority; otherwise count down and park at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/sr_latch_bank_seq.sv
`default_nettype none
// ============================================================================
// Module   : sr_latch_bank_seq
// Brief    : Write sequencer for a bank of gated SR latch cells. Drives S/R
//            with setup, pulses E, holds S/R, then checks the readback Q.
// Revision : 1.0 - initial release
// ============================================================================
module sr_latch_bank_seq
    import sr_latch_pkg::*;
#(
    parameter int NUM_LATCH = 8,
    parameter int AW        = 3,
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [AW-1:0]        cmd_addr,
    input  logic                 cmd_val,
    output logic [NUM_LATCH-1:0] lat_s,
    output logic [NUM_LATCH-1:0] lat_r,
    output logic [NUM_LATCH-1:0] lat_e,
    input  logic [NUM_LATCH-1:0] lat_q,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int c_CW = $clog2(max3(SETUP_CYC, EN_CYC, HOLD_CYC)) + 1;
    localparam logic [NUM_LATCH-1:0] c_ONE = {{(NUM_LATCH-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_state_nxt;
    logic [AW-1:0]        r_addr;
    logic                 r_val;
    logic [AW-1:0]        w_addr_nxt;
    logic                 w_val_nxt;
    logic                 w_accept;
    logic                 w_addr_ok;
    logic                 w_load;
    logic [c_CW-1:0]      w_load_val;
    logic                 w_tick;
    logic                 w_zero;
    logic [NUM_LATCH-1:0] w_oh_nxt;
    logic [NUM_LATCH-1:0] w_oh_cur;
    logic [NUM_LATCH-1:0] w_s_nxt;
    logic [NUM_LATCH-1:0] w_r_nxt;
    logic [NUM_LATCH-1:0] w_e_nxt;
    logic                 w_done_nxt;
    logic                 w_err_nxt;
    logic                 w_q_bad;

    assign w_accept   = cmd_valid & cmd_ready;
    assign w_addr_ok  = (32'(cmd_addr) < NUM_LATCH);
    assign w_addr_nxt = w_accept ? cmd_addr : r_addr;
    assign w_val_nxt  = w_accept ? cmd_val  : r_val;
    assign w_oh_nxt   = c_ONE << w_addr_nxt;
    assign w_oh_cur   = c_ONE << r_addr;
    // Readback of the addressed cell, taken on the edge that enters CHECK so
    // err is registered alongside done
    assign w_q_bad    = ((|(lat_q & w_oh_cur)) != r_val);

    phase_timer #(
        .W (c_CW)
    ) u_phase_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_tick     (w_tick),
        .o_zero     (w_zero)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= STATE_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command capture at accept; later cmd_addr/cmd_val changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_val  <= OP_CLEAR;
        end else if (w_accept) begin
            r_addr <= cmd_addr;
            r_val  <= cmd_val;
        end
    end

    // Next-state, phase timer control and next-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_tick      = 1'b0;
        case (r_state)
            STATE_IDLE: begin
                if (w_accept) begin
                    if (w_addr_ok) begin
                        w_state_nxt = STATE_SETUP;
                        w_load      = 1'b1;
                        w_load_val  = c_CW'(SETUP_CYC - 1);
                    end else begin
                        w_state_nxt = STATE_REJECT;
                    end
                end
            end
            STATE_SETUP: begin
                if (w_zero) begin
                    w_state_nxt = STATE_ENABLE;
                    w_load      = 1'b1;
                    w_load_val  = c_CW'(EN_CYC - 1);
                end else begin
                    w_tick = 1'b1;
                end
            end
            STATE_ENABLE: begin
                if (w_zero) begin
                    w_state_nxt = STATE_HOLD;
                    w_load      = 1'b1;
                    w_load_val  = c_CW'(HOLD_CYC - 1);
                end else begin
                    w_tick = 1'b1;
                end
            end
            STATE_HOLD: begin
                if (w_zero) begin
                    w_state_nxt = STATE_CHECK;
                end else begin
                    w_tick = 1'b1;
                end
            end
            default: begin
                w_state_nxt = STATE_IDLE;
            end
        endcase

        w_s_nxt    = '0;
        w_r_nxt    = '0;
        w_e_nxt    = '0;
        w_done_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        case (w_state_nxt)
            STATE_SETUP, STATE_ENABLE, STATE_HOLD: begin
                w_s_nxt = (w_val_nxt == OP_SET)   ? w_oh_nxt : '0;
                w_r_nxt = (w_val_nxt == OP_CLEAR) ? w_oh_nxt : '0;
                if (w_state_nxt == STATE_ENABLE) begin
                    w_e_nxt = w_oh_nxt;
                end
            end
            STATE_CHECK: begin
                w_done_nxt = 1'b1;
                w_err_nxt  = w_q_bad;
            end
            STATE_REJECT: begin
                w_done_nxt = 1'b1;
                w_err_nxt  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Registered outputs; reset drops every drive so the cells keep state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_s     <= '0;
            lat_r     <= '0;
            lat_e     <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            lat_s     <= w_s_nxt;
            lat_r     <= w_r_nxt;
            lat_e     <= w_e_nxt;
            cmd_ready <= (w_state_nxt == STATE_IDLE);
            busy      <= (w_state_nxt != STATE_IDLE);
            done      <= w_done_nxt;
            err       <= w_err_nxt;
        end
    end

endmodule
`default_nettype wire
